// File: rtl/rggen_apb_register_adapter.sv
// rggen_apb_register_adapter
//   Bridges an APB4 completer port onto the register-level request/response
//   bus of a register block. One register request is launched per APB
//   transfer and held until the addressed register reports ready. Read data
//   and status are collected from all attached registers and returned as a
//   registered APB response.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_psel .. i_pwdata      APB4 request (i_pprot ignored)
//   o_pready, o_prdata,
//   o_pslverr               APB4 response (registered)
//   o_register_*            request fields broadcast to every register
//   i_register_active       per-register address match (one-hot)
//   i_register_ready        per-register ready
//   i_register_status       per-register 2-bit status
//   i_register_read_data    per-register read data
module rggen_apb_register_adapter #(
    parameter int unsigned                ADDRESS_WIDTH       = 16,
    parameter int unsigned                LOCAL_ADDRESS_WIDTH = 8,
    parameter int unsigned                BUS_WIDTH           = 32,
    parameter int unsigned                REGISTERS           = 1,
    parameter bit                         PRE_DECODE          = 1'b0,
    parameter bit [ADDRESS_WIDTH-1:0]     BASE_ADDRESS        = '0,
    parameter int unsigned                BYTE_SIZE           = 256,
    parameter bit                         ERROR_STATUS        = 1'b0,
    parameter bit [BUS_WIDTH-1:0]         DEFAULT_READ_DATA   = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_psel,
    input  logic                             i_penable,
    input  logic [ADDRESS_WIDTH-1:0]         i_paddr,
    input  logic [2:0]                       i_pprot,
    input  logic                             i_pwrite,
    input  logic [BUS_WIDTH/8-1:0]           i_pstrb,
    input  logic [BUS_WIDTH-1:0]             i_pwdata,
    output logic                             o_pready,
    output logic [BUS_WIDTH-1:0]             o_prdata,
    output logic                             o_pslverr,
    output logic                             o_register_valid,
    output logic                             o_register_write,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_register_address,
    output logic [BUS_WIDTH-1:0]             o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]             i_register_active,
    input  logic [REGISTERS-1:0]             i_register_ready,
    input  logic [2*REGISTERS-1:0]           i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data
);

    typedef logic [ADDRESS_WIDTH:0]         ext_addr_t;
    typedef logic [LOCAL_ADDRESS_WIDTH-1:0] local_addr_t;

    // One extra bit so BASE_ADDRESS + BYTE_SIZE - 1 cannot wrap.
    localparam ext_addr_t   RANGE_BEGIN  = ext_addr_t'(BASE_ADDRESS);
    localparam ext_addr_t   RANGE_END    = ext_addr_t'(BASE_ADDRESS) + ext_addr_t'(BYTE_SIZE) - ext_addr_t'(1);
    localparam local_addr_t ADDRESS_MASK = ~local_addr_t'(BUS_WIDTH / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 in_range;
    logic                 hit;
    logic                 done;
    logic [BUS_WIDTH-1:0] collected_data;
    logic [1:0]           collected_status;
    logic                 register_valid;
    logic                 latch_rsp;
    logic                 force_miss;
    logic                 unused_bits;

    // Request fields follow the APB inputs, which are stable for the transfer.
    assign o_register_write      = i_pwrite;
    assign o_register_write_data = i_pwdata;
    assign o_register_strobe     = i_pwrite ? i_pstrb : '1;
    assign o_register_address    = local_addr_t'(i_paddr - BASE_ADDRESS) & ADDRESS_MASK;

    assign in_range = !PRE_DECODE ||
                      ((ext_addr_t'(i_paddr) >= RANGE_BEGIN) && (ext_addr_t'(i_paddr) <= RANGE_END));

    assign hit  = |i_register_active;
    assign done = !hit || |(i_register_active & i_register_ready);

    // Active is one-hot, so a plain OR of the gated lanes selects the hit.
    always_comb begin
        collected_data   = '0;
        collected_status = '0;
        for (int unsigned i = 0; i < REGISTERS; i++) begin
            if (i_register_active[i]) begin
                collected_data   = collected_data   | i_register_read_data[i*BUS_WIDTH +: BUS_WIDTH];
                collected_status = collected_status | i_register_status[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_next     = state;
        register_valid = 1'b0;
        latch_rsp      = 1'b0;
        force_miss     = 1'b0;
        unique case (state)
            IDLE: begin
                register_valid = i_psel && in_range;
                if (i_psel) begin
                    if (!in_range) begin
                        latch_rsp  = 1'b1;
                        force_miss = 1'b1;
                        state_next = ACK;
                    end else if (done) begin
                        latch_rsp  = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // A master dropping psel mid-transfer abandons it silently.
                register_valid = i_psel;
                if (!i_psel) begin
                    state_next = IDLE;
                end else if (done) begin
                    latch_rsp  = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_prdata  <= '0;
            o_pslverr <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_rsp) begin
                if (force_miss || !hit) begin
                    o_prdata  <= DEFAULT_READ_DATA;
                    o_pslverr <= ERROR_STATUS;
                end else begin
                    o_prdata  <= collected_data;
                    o_pslverr <= collected_status[1];
                end
            end
        end
    end

    assign o_pready = (state == ACK);
    // Reset must silence the request immediately even while psel is held.
    assign o_register_valid = register_valid && i_rst_n;

    assign unused_bits = ^{i_penable, i_pprot, collected_status[0]};

endmodule

// File: doc/rggen_apb_register_adapter.md
Name: rggen_apb_register_adapter

Overview:
Bridges an APB4 completer port onto the register-level request/response bus that feeds every per-register decode/mask stage of a register block. Launches one register request per APB transfer, holds it until the addressed register is ready, and collects the one-hot read data and status from all REGISTERS instances. Returns the collected data and status as a registered APB response. Sits between the SoC interconnect and the register array.

Parameters:
ADDRESS_WIDTH, 16, APB paddr width.
LOCAL_ADDRESS_WIDTH, 8, width of the address driven to registers.
BUS_WIDTH, 32, data width (32 or 64).
REGISTERS, 1, number of attached registers (>=1).
PRE_DECODE, 0, 1 = check paddr against [BASE_ADDRESS, BASE_ADDRESS+BYTE_SIZE-1] before launching.
BASE_ADDRESS, 0, block base address (ADDRESS_WIDTH bits).
BYTE_SIZE, 256, block size in bytes.
ERROR_STATUS, 0, 1 = a miss returns slave error; 0 = a miss returns OKAY.
DEFAULT_READ_DATA, 0, read data returned on a miss (BUS_WIDTH bits).

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_psel  input  1  APB select
i_penable  input  1  APB enable
i_paddr  input  ADDRESS_WIDTH  APB address
i_pprot  input  3  ignored
i_pwrite  input  1  APB write
i_pstrb  input  BUS_WIDTH/8  APB byte strobe
i_pwdata  input  BUS_WIDTH  APB write data
o_pready  output  1  APB ready
o_prdata  output  BUS_WIDTH  APB read data
o_pslverr  output  1  APB error
o_register_valid  output  1  request to registers
o_register_write  output  1  1 = write
o_register_address  output  LOCAL_ADDRESS_WIDTH  local byte address
o_register_write_data  output  BUS_WIDTH  write data
o_register_strobe  output  BUS_WIDTH/8  byte strobe
i_register_active  input  REGISTERS  per-register address match
i_register_ready  input  REGISTERS  per-register ready
i_register_status  input  2*REGISTERS  per-register status (0 OKAY, 1 EXOKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR)
i_register_read_data  input  BUS_WIDTH*REGISTERS  per-register read data

Behaviour:
- Clock i_clk; reset asynchronous, active-low on i_rst_n. Reset: state IDLE, o_pready 0, o_prdata 0, o_pslverr 0, o_register_valid 0.
- Request fields are combinational from APB inputs (stable for the whole transfer). Address = (i_paddr - BASE_ADDRESS) truncated to LOCAL_ADDRESS_WIDTH, low log2(BUS_WIDTH/8) bits forced 0. Strobe = i_pstrb on write, all-ones on read.
- in_range = 1 when PRE_DECODE=0, else BASE_ADDRESS <= i_paddr <= BASE_ADDRESS+BYTE_SIZE-1.
- hit = |i_register_active; done = !hit || |(i_register_active & i_register_ready).
- Collected data = OR over i of (active[i] ? read_data[i] : 0). Collected status = OR of the active statuses. Active is one-hot by construction; multi-hit is not checked.
- Miss: data = DEFAULT_READ_DATA; status = ERROR_STATUS ? SLAVE_ERROR : OKAY. Write responses also latch collected data (don't-care on APB).
- FSM:
  - IDLE: o_register_valid = i_psel & in_range.
    - i_psel & !in_range: latch miss response -> ACK.
    - i_psel & in_range & done: latch collected -> ACK.
    - i_psel & in_range & !done: -> BUSY.
  - BUSY: o_register_valid = 1. When done: latch collected -> ACK.
  - ACK: o_pready = 1; o_pslverr = latched status[1]; o_prdata = latched data; o_register_valid = 0. Always -> IDLE next cycle.
- Latency: a zero-wait register returns pready in the cycle after the setup phase, i.e. an APB transfer with no wait states. Each cycle the register holds ready low adds one APB wait state.
- o_prdata and o_pslverr hold their last latched values outside ACK.
- psel deasserted in BUSY (protocol violation): return to IDLE, drop valid, produce no ACK.
- Back-to-back transfers: the ACK->IDLE transition guarantees at least one idle cycle on o_register_valid between requests.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at their reset values; the aborted transfer produces no pready.

Test Plan:
- Read, paddr=0x0004, register 1 of 4 active+ready, read_data=0xDEADBEEF, status 0 -> valid 1 cycle, address 0x04, pready in the cycle after setup, prdata 0xDEADBEEF, pslverr 0.
- Write, pwdata 0x12345678, pstrb 4'b0011, register 0 ready after 3 cycles of active&!ready -> valid held 4 cycles with strobe 0011, write_data 0x12345678, pready 1 cycle later; 3 APB wait states.
- Miss (no active), ERROR_STATUS=1, DEFAULT_READ_DATA=0xFFFFFFFF -> pslverr 1, prdata 0xFFFFFFFF. Same stimulus with ERROR_STATUS=0 -> pslverr 0.
- PRE_DECODE=1, BASE_ADDRESS=0x100, BYTE_SIZE=0x40, paddr 0x140 -> o_register_valid never asserted, pslverr=ERROR_STATUS. paddr 0x13C -> address 0x3C launched.
- Register status 2 on a hit -> pslverr 1. Status 1 -> pslverr 0.
- i_rst_n low during BUSY -> valid 0, pready 0, prdata 0 asynchronously. The next transfer after reset completes normally.
